// File: rtl/bus_arbiter_2p_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2p_pkg
//   Shared constants and types for the two-port memory bus arbiter.
//   - ARB_* : owner / grant encodings (legacy 2-bit values kept stable so
//             existing debug scripts can decode dbg_owner directly).
//   - DSZ_* : data_size encodings shared with the Memory stage.
//   - bus_req_t : one port's view of the downstream request bundle.
// ---------------------------------------------------------------------------
package bus_arbiter_2p_pkg;

    localparam logic [1:0] ARB_NONE = 2'b00;
    localparam logic [1:0] ARB_I    = 2'b01;
    localparam logic [1:0] ARB_D    = 2'b10;

    localparam logic [2:0] DSZ_BYTE = 3'b001;
    localparam logic [2:0] DSZ_HALF = 3'b010;
    localparam logic [2:0] DSZ_WORD = 3'b100;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd_req;
        logic        wr_req;
        logic [31:0] wr_data;
        logic [2:0]  data_size;
    } bus_req_t;

    // A port "requests" when either direction is asserted; D may assert
    // both at once and that combination is forwarded as-is.
    function automatic logic req_of(input bus_req_t r);
        return r.rd_req | r.wr_req;
    endfunction

endpackage

// File: rtl/bus_arbiter_2p_arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
//   Saturating up-counter tracking how long the fetch port has been kept
//   waiting. Clear has priority over increment.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : count one more waiting cycle (stops at LIMIT)
//     clr        : return to zero
//     cnt        : current count (debug visibility)
//     sat        : cnt == LIMIT
// ---------------------------------------------------------------------------
module arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat = (cnt_q == W'(LIMIT));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_arbiter_2p.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2p
//   Shares the single system memory bus between instruction fetch (I, read
//   only) and the Memory-stage data port (D). Uncontended accesses pass
//   straight through with no added latency. D wins contention unless the
//   fetch port has waited STARVE_LIMIT cycles. D can hold the bus across
//   multi-access sequences with d_lock.
//
//   Handshake (all three ports): a port raises rd_req/wr_req with address and
//   data stable; the access completes in a cycle where the request is high
//   and rw_wait is low. rw_wait is combinational. A request may be dropped
//   while stalled (pipeline flush); that abandons the access.
//
//   Ports:
//     clk, Nrst                    : clock, asynchronous active-low reset
//     i_busaddr/i_rd_req           : fetch request     -> i_rw_wait, i_rd_data
//     d_busaddr/d_rd_req/d_wr_req/
//     d_wr_data/d_data_size/d_lock : data request      -> d_rw_wait, d_rd_data
//     m_*                          : downstream bus (m_rw_wait, m_rd_data in)
//     dbg_owner, dbg_starve_cnt    : registered state for observation
// ---------------------------------------------------------------------------
module bus_arbiter_2p
    import bus_arbiter_2p_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             Nrst,
    // fetch port
    input  logic [31:0]      i_busaddr,
    input  logic             i_rd_req,
    output logic             i_rw_wait,
    output logic [31:0]      i_rd_data,
    // data port
    input  logic [31:0]      d_busaddr,
    input  logic             d_rd_req,
    input  logic             d_wr_req,
    input  logic [31:0]      d_wr_data,
    input  logic [2:0]       d_data_size,
    input  logic             d_lock,
    output logic             d_rw_wait,
    output logic [31:0]      d_rd_data,
    // downstream bus
    output logic [31:0]      m_busaddr,
    output logic             m_rd_req,
    output logic             m_wr_req,
    output logic [31:0]      m_wr_data,
    output logic [2:0]       m_data_size,
    input  logic             m_rw_wait,
    input  logic [31:0]      m_rd_data,
    // debug
    output logic [1:0]       dbg_owner,
    output logic [CNT_W-1:0] dbg_starve_cnt
);

    logic [1:0] owner_q;
    logic [1:0] owner_d;
    logic [1:0] grant;

    bus_req_t   i_bus;
    bus_req_t   d_bus;
    bus_req_t   m_bus;

    logic       i_req;
    logic       d_req;
    logic       lock_hold;
    logic       starve_sat;
    logic       starve_inc;
    logic       starve_clr;

    // Fetch never writes; it always reads a full word.
    assign i_bus = '{addr: i_busaddr, rd_req: i_rd_req, wr_req: 1'b0,
                     wr_data: 32'h0, data_size: DSZ_WORD};
    assign d_bus = '{addr: d_busaddr, rd_req: d_rd_req, wr_req: d_wr_req,
                     wr_data: d_wr_data, data_size: d_data_size};

    assign i_req = req_of(i_bus);
    assign d_req = req_of(d_bus);

    // D keeps the bus between the accesses of a locked sequence even in
    // cycles where it has no request up; starvation cannot break this.
    assign lock_hold = (owner_q == ARB_D) && d_lock;

    // Grant. An owner whose request has dropped (flush) loses the bus at
    // once and the cycle is re-arbitrated. The starvation flip is only
    // consulted here, at a free arbitration point.
    always_comb begin
        grant = ARB_NONE;
        if (!Nrst) begin
            grant = ARB_NONE;
        end else if (lock_hold) begin
            grant = d_req ? ARB_D : ARB_NONE;
        end else if ((owner_q == ARB_I) && i_req) begin
            grant = ARB_I;
        end else if ((owner_q == ARB_D) && d_req) begin
            grant = ARB_D;
        end else if (i_req && d_req) begin
            grant = starve_sat ? ARB_I : ARB_D;
        end else if (i_req) begin
            grant = ARB_I;
        end else if (d_req) begin
            grant = ARB_D;
        end
    end

    // Forwarding mux
    always_comb begin
        m_bus = '0;
        case (grant)
            ARB_I:   m_bus = i_bus;
            ARB_D:   m_bus = d_bus;
            default: m_bus = '0;
        endcase
    end

    assign m_busaddr   = m_bus.addr;
    assign m_rd_req    = m_bus.rd_req;
    assign m_wr_req    = m_bus.wr_req;
    assign m_wr_data   = m_bus.wr_data;
    assign m_data_size = m_bus.data_size;

    assign i_rw_wait = (grant == ARB_I) ? m_rw_wait : 1'b1;
    assign d_rw_wait = (grant == ARB_D) ? m_rw_wait : 1'b1;
    assign i_rd_data = m_rd_data;
    assign d_rd_data = m_rd_data;

    // Next owner: hold through a stall, keep D across a locked sequence
    // (including idle gaps inside it), otherwise release.
    always_comb begin
        owner_d = ARB_NONE;
        if ((grant != ARB_NONE) && m_rw_wait) begin
            owner_d = grant;
        end else if (d_lock && ((grant == ARB_D) || (owner_q == ARB_D))) begin
            owner_d = ARB_D;
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            owner_q <= ARB_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // A granted-but-stalled fetch neither counts up nor clears.
    assign starve_clr = !i_rd_req || ((grant == ARB_I) && !m_rw_wait);
    assign starve_inc = i_rd_req && (grant != ARB_I);

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (Nrst),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .cnt   (dbg_starve_cnt),
        .sat   (starve_sat)
    );

    assign dbg_owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter_2p.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_2p
//   Directed, table-driven bench. Each table row is one clock cycle: the
//   inputs applied and the hand-computed grant, rw_wait values and the
//   registered owner/starve count present during that cycle. The asynchronous
//   reset corner is a hand-written sequence after the table.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_2p;

    // ---------------- clock / reset ----------------
    logic clk;
    logic Nrst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0] i_busaddr;
    logic        i_rd_req;
    logic        i_rw_wait;
    logic [31:0] i_rd_data;
    logic [31:0] d_busaddr;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [31:0] d_wr_data;
    logic [2:0]  d_data_size;
    logic        d_lock;
    logic        d_rw_wait;
    logic [31:0] d_rd_data;
    logic [31:0] m_busaddr;
    logic        m_rd_req;
    logic        m_wr_req;
    logic [31:0] m_wr_data;
    logic [2:0]  m_data_size;
    logic        m_rw_wait;
    logic [31:0] m_rd_data;
    logic [1:0]  dbg_owner;
    logic [2:0]  dbg_starve_cnt;

    bus_arbiter_2p #(
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .clk            (clk),
        .Nrst           (Nrst),
        .i_busaddr      (i_busaddr),
        .i_rd_req       (i_rd_req),
        .i_rw_wait      (i_rw_wait),
        .i_rd_data      (i_rd_data),
        .d_busaddr      (d_busaddr),
        .d_rd_req       (d_rd_req),
        .d_wr_req       (d_wr_req),
        .d_wr_data      (d_wr_data),
        .d_data_size    (d_data_size),
        .d_lock         (d_lock),
        .d_rw_wait      (d_rw_wait),
        .d_rd_data      (d_rd_data),
        .m_busaddr      (m_busaddr),
        .m_rd_req       (m_rd_req),
        .m_wr_req       (m_wr_req),
        .m_wr_data      (m_wr_data),
        .m_data_size    (m_data_size),
        .m_rw_wait      (m_rw_wait),
        .m_rd_data      (m_rd_data),
        .dbg_owner      (dbg_owner),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- vector table ----------------
    localparam logic [1:0] G_N = 2'd0;
    localparam logic [1:0] G_I = 2'd1;
    localparam logic [1:0] G_D = 2'd2;
    localparam logic [2:0] SZ_B = 3'b001;
    localparam logic [2:0] SZ_W = 3'b100;

    typedef struct {
        logic        i_rq;
        logic [31:0] i_ad;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] d_ad;
        logic [2:0]  d_sz;
        logic        d_lk;
        logic        m_wt;
        logic [1:0]  e_gnt;
        logic        e_iw;
        logic        e_dw;
        logic [1:0]  e_own;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic i_rq, input logic [31:0] i_ad,
                                input logic d_rd, input logic d_wr,
                                input logic [31:0] d_ad, input logic [2:0] d_sz,
                                input logic d_lk, input logic m_wt,
                                input logic [1:0] e_gnt, input logic e_iw,
                                input logic e_dw, input logic [1:0] e_own,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.i_rq = i_rq;  v.i_ad = i_ad;  v.d_rd = d_rd;  v.d_wr = d_wr;
        v.d_ad = d_ad;  v.d_sz = d_sz;  v.d_lk = d_lk;  v.m_wt = m_wt;
        v.e_gnt = e_gnt; v.e_iw = e_iw; v.e_dw = e_dw;
        v.e_own = e_own; v.e_cnt = e_cnt;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        i_busaddr = 32'h0; i_rd_req = 1'b0;
        d_busaddr = 32'h0; d_rd_req = 1'b0; d_wr_req = 1'b0;
        d_wr_data = 32'h0; d_data_size = SZ_W; d_lock = 1'b0;
        m_rw_wait = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [31:0] e_addr;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_wdat;
        logic [2:0]  e_sz;
        logic [31:0] rdat;
        string       tag;

        @(posedge clk);
        #1;
        rdat        = 32'hC0DE_0000 + 32'(idx);
        i_rd_req    = v.i_rq;
        i_busaddr   = v.i_ad;
        d_rd_req    = v.d_rd;
        d_wr_req    = v.d_wr;
        d_busaddr   = v.d_ad;
        d_wr_data   = v.d_ad ^ 32'hDEAD_0000;
        d_data_size = v.d_sz;
        d_lock      = v.d_lk;
        m_rw_wait   = v.m_wt;
        m_rd_data   = rdat;

        // Expected downstream bundle follows the hand-computed grant.
        e_addr = 32'h0; e_rd = 1'b0; e_wr = 1'b0; e_wdat = 32'h0; e_sz = 3'b000;
        if (v.e_gnt == G_I) begin
            e_addr = v.i_ad; e_rd = 1'b1; e_sz = SZ_W;
        end else if (v.e_gnt == G_D) begin
            e_addr = v.d_ad; e_rd = v.d_rd; e_wr = v.d_wr;
            e_wdat = v.d_ad ^ 32'hDEAD_0000; e_sz = v.d_sz;
        end

        #3;
        tag = $sformatf("v%0d", idx);
        check({tag, " m_rd_req"},    32'(m_rd_req),    32'(e_rd));
        check({tag, " m_wr_req"},    32'(m_wr_req),    32'(e_wr));
        check({tag, " m_busaddr"},   m_busaddr,        e_addr);
        check({tag, " m_wr_data"},   m_wr_data,        e_wdat);
        check({tag, " m_data_size"}, 32'(m_data_size), 32'(e_sz));
        check({tag, " i_rw_wait"},   32'(i_rw_wait),   32'(v.e_iw));
        check({tag, " d_rw_wait"},   32'(d_rw_wait),   32'(v.e_dw));
        check({tag, " owner"},       32'(dbg_owner),   32'(v.e_own));
        check({tag, " starve_cnt"},  32'(dbg_starve_cnt), 32'(v.e_cnt));
        check({tag, " i_rd_data"},   i_rd_data,        rdat);
        check({tag, " d_rd_data"},   d_rd_data,        rdat);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive_idle();
        m_rd_data = 32'h0;
        Nrst = 1'b0;

        // Requests held during reset must not reach the bus.
        i_rd_req = 1'b1; i_busaddr = 32'h100;
        d_rd_req = 1'b1; d_busaddr = 32'h200;
        #12;
        check("rst m_rd_req",  32'(m_rd_req),  32'd0);
        check("rst m_wr_req",  32'(m_wr_req),  32'd0);
        check("rst i_rw_wait", 32'(i_rw_wait), 32'd1);
        check("rst d_rw_wait", 32'(d_rw_wait), 32'd1);
        check("rst owner",     32'(dbg_owner), 32'd0);
        check("rst cnt",       32'(dbg_starve_cnt), 32'd0);
        drive_idle();
        @(negedge clk);
        Nrst = 1'b1;

        //               i_rq i_ad          d_rd d_wr d_ad          sz    lk   mw    gnt  iw   dw   own  cnt
        // 1: fetch alone, zero wait, owner stays NONE
        vecs[0]  = mk(1, 32'h100, 0, 0, 32'h0,   SZ_W, 0, 0, G_N+2'd1, 0, 1, G_N, 3'd0);
        vecs[1]  = mk(0, 32'h0,   0, 0, 32'h0,   SZ_W, 0, 0, G_N, 1, 1, G_N, 3'd0);
        // 2: contention, D write with two wait cycles, I gets the bus on cycle 4
        vecs[2]  = mk(1, 32'h104, 0, 1, 32'h200, SZ_W, 0, 1, G_D, 1, 1, G_N, 3'd0);
        vecs[3]  = mk(1, 32'h104, 0, 1, 32'h200, SZ_W, 0, 1, G_D, 1, 1, G_D, 3'd1);
        vecs[4]  = mk(1, 32'h104, 0, 1, 32'h200, SZ_W, 0, 0, G_D, 1, 0, G_D, 3'd2);
        vecs[5]  = mk(1, 32'h104, 0, 0, 32'h0,   SZ_W, 0, 0, G_I, 0, 1, G_N, 3'd3);
        // 3: D back-to-back, I pending; I wins the 5th arbitration
        vecs[6]  = mk(1, 32'h108, 1, 0, 32'h220, SZ_W, 0, 0, G_D, 1, 0, G_N, 3'd0);
        vecs[7]  = mk(1, 32'h108, 1, 0, 32'h224, SZ_W, 0, 0, G_D, 1, 0, G_N, 3'd1);
        vecs[8]  = mk(1, 32'h108, 1, 0, 32'h228, SZ_W, 0, 0, G_D, 1, 0, G_N, 3'd2);
        vecs[9]  = mk(1, 32'h108, 1, 0, 32'h22C, SZ_W, 0, 0, G_D, 1, 0, G_N, 3'd3);
        vecs[10] = mk(1, 32'h108, 1, 0, 32'h230, SZ_W, 0, 0, G_I, 0, 1, G_N, 3'd4);
        vecs[11] = mk(1, 32'h10C, 1, 0, 32'h230, SZ_W, 0, 0, G_D, 1, 0, G_N, 3'd0);
        vecs[12] = mk(0, 32'h0,   0, 0, 32'h0,   SZ_W, 0, 0, G_N, 1, 1, G_N, 3'd1);
        // 4: locked STRB sequence with an idle gap; saturation does not break it
        vecs[13] = mk(1, 32'h110, 1, 0, 32'h203, SZ_B, 1, 1, G_D, 1, 1, G_N, 3'd0);
        vecs[14] = mk(1, 32'h110, 1, 0, 32'h203, SZ_B, 1, 0, G_D, 1, 0, G_D, 3'd1);
        vecs[15] = mk(1, 32'h110, 0, 0, 32'h0,   SZ_B, 1, 0, G_N, 1, 1, G_D, 3'd2);
        vecs[16] = mk(1, 32'h110, 0, 1, 32'h203, SZ_B, 1, 0, G_D, 1, 0, G_D, 3'd3);
        vecs[17] = mk(1, 32'h110, 0, 0, 32'h0,   SZ_W, 1, 0, G_N, 1, 1, G_D, 3'd4);
        vecs[18] = mk(1, 32'h110, 0, 0, 32'h0,   SZ_W, 0, 0, G_I, 0, 1, G_D, 3'd4);
        // 5: D flushed mid-stall, I forwarded the same cycle and holds through its stall
        vecs[19] = mk(1, 32'h114, 1, 0, 32'h300, SZ_W, 0, 1, G_D, 1, 1, G_N, 3'd0);
        vecs[20] = mk(1, 32'h114, 0, 0, 32'h300, SZ_W, 0, 1, G_I, 1, 1, G_D, 3'd1);
        vecs[21] = mk(1, 32'h114, 1, 0, 32'h304, SZ_W, 0, 0, G_I, 0, 1, G_I, 3'd1);
        vecs[22] = mk(0, 32'h0,   0, 0, 32'h0,   SZ_W, 0, 0, G_N, 1, 1, G_N, 3'd0);

        for (int k = 0; k < NV; k++) begin
            apply_vec(vecs[k], k);
        end

        // 6: asynchronous reset during a stalled D read
        @(posedge clk);
        #1;
        drive_idle();
        i_rd_req = 1'b1; i_busaddr = 32'h118;
        d_rd_req = 1'b1; d_busaddr = 32'h400;
        m_rw_wait = 1'b1;
        #3;
        check("ar pre m_rd_req", 32'(m_rd_req), 32'd1);
        check("ar pre m_busaddr", m_busaddr, 32'h400);
        @(posedge clk);
        #2;
        check("ar owner held", 32'(dbg_owner), 32'd2);
        check("ar cnt 1",      32'(dbg_starve_cnt), 32'd1);
        Nrst = 1'b0;
        #1;
        check("ar m_rd_req async", 32'(m_rd_req),  32'd0);
        check("ar d_rw_wait",      32'(d_rw_wait), 32'd1);
        check("ar i_rw_wait",      32'(i_rw_wait), 32'd1);
        check("ar owner cleared",  32'(dbg_owner), 32'd0);
        check("ar cnt cleared",    32'(dbg_starve_cnt), 32'd0);
        @(negedge clk);
        Nrst = 1'b1;
        drive_idle();
        @(posedge clk);
        #4;
        check("ar post owner", 32'(dbg_owner), 32'd0);
        check("ar post cnt",   32'(dbg_starve_cnt), 32'd0);
        // D retries after release and completes without wait
        d_rd_req = 1'b1; d_busaddr = 32'h400;
        #1;
        check("ar retry m_rd_req",  32'(m_rd_req),  32'd1);
        check("ar retry m_busaddr", m_busaddr,      32'h400);
        check("ar retry d_rw_wait", 32'(d_rw_wait), 32'd0);
        @(posedge clk);
        #1;
        drive_idle();
        #3;
        check("ar end owner", 32'(dbg_owner), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
